seq_mult_param: RTL and testbench

//  Parametrised sequential shift-add multiplier: integrated control FSM, iteration counter and datapath.

---
 rtl/seq_mult_param.sv | 123 ++++++++++++
 tb/tb_seq_mult_param.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier with optional radix-2 Booth (signed) mode.
// One ADD/SHIFT pair per operand bit; fixed latency of 2*WIDTH+1 cycles from Load to Done.
module seq_mult_param #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic               Clk,
    input  logic               rst_n,
    input  logic               St,
    input  logic               Sgn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Idle,
    output logic               Load,
    output logic               Ad,
    output logic               Sh,
    output logic               Done,
    output logic [2*WIDTH-1:0] P
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned AW = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [AW-1:0]    acc;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic             mode;

    logic             add_op;
    logic             sub_op;
    logic [AW-1:0]    a_ext;
    logic [AW-1:0]    acc_base;
    logic [AW-1:0]    acc_next;

    // Unsigned: acc[WIDTH] is the carry of the last add and is dropped before the next one.
    // Signed: acc is a true (WIDTH+1)-bit two's-complement value so -2^(W-1) can be negated.
    always_comb begin
        add_op   = 1'b0;
        sub_op   = 1'b0;
        a_ext    = {1'b0, a_reg};
        acc_base = {1'b0, acc[WIDTH-1:0]};
        if (mode) begin
            add_op   = ~q[0] & q_m1;
            sub_op   = q[0] & ~q_m1;
            a_ext    = {a_reg[WIDTH-1], a_reg};
            acc_base = acc;
        end else begin
            add_op   = q[0];
        end
        acc_next = acc_base;
        if (sub_op)
            acc_next = acc_base - a_ext;
        else if (add_op)
            acc_next = acc_base + a_ext;
    end

    assign Idle = (state == S_IDLE);
    assign Load = (state == S_IDLE) && St;
    assign Ad   = (state == S_ADD) && (add_op || sub_op);
    assign Sh   = (state == S_SHIFT);
    assign Done = (state == S_DONE);

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            a_reg <= '0;
            acc   <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            mode  <= 1'b0;
            P     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (St) begin
                        a_reg <= A;
                        q     <= B;
                        q_m1  <= 1'b0;
                        acc   <= '0;
                        mode  <= Sgn & SIGNED_EN;
                        cnt   <= CW'(WIDTH - 1);
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    acc   <= acc_next;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // acc[WIDTH] is the carry (unsigned) or the sign (signed): same fill either way.
                    acc  <= {acc[WIDTH], acc[WIDTH:1]};
                    q    <= {acc[0], q[WIDTH-1:1]};
                    q_m1 <= q[0];
                    if (cnt == '0) begin
                        P     <= {acc, q[WIDTH-1:1]};
                        state <= S_DONE;
                    end else begin
                        cnt   <= cnt - CW'(1);
                        state <= S_ADD;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: table vectors, random operands against an arithmetic reference,
// plus reset-mid-operation, St-during-operation and back-to-back sequences.
module tb_seq_mult_param;

    localparam int unsigned W = 8;

    logic           Clk = 1'b0;
    logic           rst_n;
    logic           St;
    logic           Sgn;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           Idle, Load, Ad, Sh, Done;
    logic [2*W-1:0] P;
    logic           Idle_u, Load_u, Ad_u, Sh_u, Done_u;
    logic [2*W-1:0] P_u;

    int n_pass  = 0;
    int n_total = 0;

    always #5 Clk = ~Clk;

    seq_mult_param #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .Clk(Clk), .rst_n(rst_n), .St(St), .Sgn(Sgn), .A(A), .B(B),
        .Idle(Idle), .Load(Load), .Ad(Ad), .Sh(Sh), .Done(Done), .P(P)
    );

    seq_mult_param #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .Clk(Clk), .rst_n(rst_n), .St(St), .Sgn(Sgn), .A(A), .B(B),
        .Idle(Idle_u), .Load(Load_u), .Ad(Ad_u), .Sh(Sh_u), .Done(Done_u), .P(P_u)
    );

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        bit             sgn;
        logic [2*W-1:0] exp_p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input bit sgn);
        int sa, sb;
        if (sgn) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
        end else begin
            sa = int'(a);
            sb = int'(b);
        end
        return (2*W)'(sa * sb);
    endfunction

    // Unsigned: one add per set multiplier bit; Booth: one add/sub per bit transition (B[-1]=0).
    function automatic int ref_adds(input logic [W-1:0] b, input bit sgn);
        logic [W-1:0] t;
        t = b ^ {b[W-2:0], 1'b0};
        return sgn ? $countones(t) : $countones(b);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                          input logic [2*W-1:0] exp_p, input bit st_mid, input string tag);
        int n, sh, ad, adu;
        bit seen;
        A = a; B = b; Sgn = sgn; St = 1'b1;
        #1;
        chk({tag, " load"}, 32'({Idle, Load}), 32'h3);
        @(posedge Clk); #1;
        St = 1'b0; A = W'($urandom); B = W'($urandom); Sgn = ~sgn;
        n = 1; sh = 0; ad = 0; adu = 0; seen = 1'b0;
        while (n <= 40) begin
            if (Done) begin
                seen = 1'b1;
                break;
            end
            sh  += int'(Sh);
            ad  += int'(Ad);
            adu += int'(Ad_u);
            St = st_mid && (n >= 2) && (n <= 10);
            @(posedge Clk); #1;
            n++;
        end
        St = 1'b0;
        chk({tag, " latency"}, seen ? 32'(n) : 32'hFFFF, 32'd17);
        chk({tag, " shifts"}, 32'(sh), 32'd8);
        chk({tag, " P"}, 32'(P), 32'(exp_p));
        chk({tag, " P_unsigned"}, 32'(P_u), 32'(ref_prod(a, b, 1'b0)));
        chk({tag, " adds"}, 32'(ad), 32'(ref_adds(b, sgn)));
        chk({tag, " adds_unsigned"}, 32'(adu), 32'(ref_adds(b, 1'b0)));
        chk({tag, " done_u"}, 32'(Done_u), 32'd1);
        @(posedge Clk); #1;
        chk({tag, " back_idle"}, 32'({Idle, Done, Sh}), 32'h4);
        chk({tag, " P_held"}, 32'(P), 32'(exp_p));
    endtask

    initial begin
        vec_t vecs[$];
        logic [W-1:0] ra, rb;
        bit rs;
        int cyc, nd, ndone;
        int dcyc[3];

        vecs.push_back('{8'hFF, 8'hFF, 1'b0, 16'hFE01});
        vecs.push_back('{8'h80, 8'h80, 1'b1, 16'h4000});
        vecs.push_back('{8'hFD, 8'h05, 1'b1, 16'hFFF1});
        vecs.push_back('{8'hFD, 8'h05, 1'b0, 16'h04F1});
        vecs.push_back('{8'h00, 8'h37, 1'b0, 16'h0000});
        vecs.push_back('{8'h5A, 8'h00, 1'b0, 16'h0000});
        vecs.push_back('{8'h7F, 8'h7F, 1'b1, 16'h3F01});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 16'h0001});
        vecs.push_back('{8'h80, 8'h7F, 1'b1, 16'hC080});
        vecs.push_back('{8'h7F, 8'h80, 1'b1, 16'hC080});

        rst_n = 1'b0; St = 1'b0; Sgn = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset flags", 32'({Idle, Load, Ad, Sh, Done}), 32'h10);
        chk("reset P", 32'({P, P_u}), 32'h0);
        rst_n = 1'b1;
        @(posedge Clk); #1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].exp_p, 1'b0, "vec");

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rs, ref_prod(ra, rb, rs), 1'b0, "rand");
        end

        // St asserted during ADD/SHIFT must neither restart nor queue an operation.
        run_op(8'hC3, 8'h5B, 1'b1, ref_prod(8'hC3, 8'h5B, 1'b1), 1'b1, "st_mid");
        ndone = 0;
        repeat (4) begin
            @(posedge Clk); #1;
            ndone += int'(Sh || Done || !Idle);
        end
        chk("st_mid no_restart", 32'(ndone), 32'd0);

        // St held high: back-to-back operations every 2*W+2 cycles.
        A = 8'h03; B = 8'h05; Sgn = 1'b0; St = 1'b1;
        nd = 0; cyc = 0;
        while (cyc < 100 && nd < 3) begin
            @(posedge Clk); #1;
            cyc++;
            if (Done) begin
                dcyc[nd] = cyc;
                nd++;
                if (nd == 3) St = 1'b0;
            end
        end
        St = 1'b0;
        chk("b2b count", 32'(nd), 32'd3);
        chk("b2b period1", 32'(dcyc[1] - dcyc[0]), 32'd18);
        chk("b2b period2", 32'(dcyc[2] - dcyc[1]), 32'd18);
        chk("b2b P", 32'(P), 32'h000F);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("b2b stop", 32'({Idle, Sh}), 32'h2);

        // Reset at cycle 6 of an operation discards it and clears P.
        A = 8'hFF; B = 8'hFF; Sgn = 1'b0; St = 1'b1;
        @(posedge Clk); #1;
        St = 1'b0;
        repeat (5) begin
            @(posedge Clk); #1;
        end
        rst_n = 1'b0;
        @(posedge Clk); #1;
        rst_n = 1'b1;
        chk("midrst flags", 32'({Idle, Load, Ad, Sh, Done}), 32'h10);
        chk("midrst P", 32'({P, P_u}), 32'h0);
        ndone = 0;
        repeat (25) begin
            @(posedge Clk); #1;
            ndone += int'(Done || Done_u);
        end
        chk("midrst no_done", 32'(ndone), 32'd0);

        run_op(8'h12, 8'h34, 1'b0, 16'h03A8, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
